// File: rtl/ledr_seq_pkg.sv
// Shared definitions for the LEDR sequencer: register map, mode and state
// encodings, and the CTRL register layout.
package ledr_seq_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_MODE_LSB   = 1;
  localparam int CTRL_IRQ_EN_BIT = 3;
  localparam int CTRL_W          = 4;

  localparam int STATUS_DONE_BIT = 0;
  localparam int STATUS_RUN_BIT  = 1;

  typedef enum logic [1:0] {
    MODE_STATIC    = 2'd0,
    MODE_BLINK     = 2'd1,
    MODE_CHASE     = 2'd2,
    MODE_COUNTDOWN = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Field order mirrors the CTRL bit layout so the struct can be cast directly.
  typedef struct packed {
    logic  irq_en;
    mode_e mode;
    logic  enable;
  } ctrl_t;

endpackage

// File: rtl/ledr_tick_gen.sv
// Step prescaler: a down-counter that fires a one-cycle tick each time it
// passes through zero and then reloads.
module ledr_tick_gen #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                run,
  input  logic [PERIOD_W-1:0] reload_val,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                cnt_d = reload_val;
    else if (!run)           cnt_d = '0;
    else if (cnt_q == '0)    cnt_d = reload_val;
    else                     cnt_d = cnt_q - 1'b1;
  end

  assign tick = run & ~load & (cnt_q == '0);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ledr_sequencer.sv
// Avalon-MM LEDR pattern sequencer: static, blink, chase and countdown modes
// stepped by a programmable prescaler, with a sticky done flag and IRQ.
module ledr_sequencer
  import ledr_seq_pkg::*;
#(
  parameter int LED_W    = 18,
  parameter int PERIOD_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] out_port,
  output logic             irq
);

  ctrl_t               ctrl_q, ctrl_d;
  logic [LED_W-1:0]    pattern_q, pattern_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [LED_W-1:0]    work_q, work_d;
  logic                phase_q, phase_d;
  logic                done_q, done_d;
  state_e              state_q, state_d;
  logic [LED_W-1:0]    out_port_q, out_port_d;
  logic                irq_q, irq_d;

  logic                wr, wr_ctrl, wr_pattern, wr_period, wr_status;
  logic                done_set, tick, tick_run;
  logic [PERIOD_W-1:0] reload_val;
  logic                unused_wdata;

  assign wr         = chipselect & ~write_n;
  assign wr_ctrl    = wr & (address == ADDR_CTRL);
  assign wr_pattern = wr & (address == ADDR_PATTERN);
  assign wr_period  = wr & (address == ADDR_PERIOD);
  assign wr_status  = wr & (address == ADDR_STATUS);
  assign unused_wdata = ^writedata;

  // A PERIOD of 0 steps every cycle, same as 1.
  assign reload_val = (period_q == '0) ? '0 : period_q - 1'b1;
  assign tick_run   = (state_q == ST_RUN) & ~wr_ctrl;

  ledr_tick_gen #(.PERIOD_W(PERIOD_W)) u_tick (
    .clk        (clk),
    .rst_n      (reset_n),
    .load       (wr_ctrl & writedata[CTRL_EN_BIT]),
    .run        (tick_run),
    .reload_val (reload_val),
    .tick       (tick)
  );

  always_comb begin
    ctrl_d    = wr_ctrl    ? ctrl_t'(writedata[CTRL_W-1:0]) : ctrl_q;
    pattern_d = wr_pattern ? writedata[LED_W-1:0]           : pattern_q;
    period_d  = wr_period  ? writedata[PERIOD_W-1:0]        : period_q;
    state_d   = state_q;
    work_d    = work_q;
    phase_d   = phase_q;
    done_set  = 1'b0;

    if (wr_ctrl) begin
      if (ctrl_d.enable) begin
        state_d = ST_RUN;
        work_d  = (ctrl_d.mode == MODE_COUNTDOWN) ? '1 : pattern_q;
        phase_d = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (tick) begin
      unique case (ctrl_q.mode)
        MODE_BLINK: phase_d = ~phase_q;
        MODE_CHASE: work_d  = {work_q[LED_W-2:0], work_q[LED_W-1]};
        MODE_COUNTDOWN: begin
          work_d = work_q >> 1;
          if (work_d == '0) begin
            state_d  = ST_DONE;
            done_set = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Set has priority over a same-cycle clear.
    done_d = done_q;
    if (wr_status && writedata[STATUS_DONE_BIT]) done_d = 1'b0;
    if (done_set)                                done_d = 1'b1;

    // Output is formed from next-state values so it lands on the same edge.
    out_port_d = '0;
    if (state_d == ST_RUN) begin
      unique case (ctrl_d.mode)
        MODE_STATIC: out_port_d = pattern_d;
        MODE_BLINK:  out_port_d = phase_d ? pattern_d : '0;
        default:     out_port_d = work_d;
      endcase
    end

    irq_d = done_q & ctrl_q.irq_en;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= '0;
      pattern_q  <= '0;
      period_q   <= '0;
      work_q     <= '0;
      phase_q    <= 1'b0;
      done_q     <= 1'b0;
      state_q    <= ST_IDLE;
      out_port_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      pattern_q  <= pattern_d;
      period_q   <= period_d;
      work_q     <= work_d;
      phase_q    <= phase_d;
      done_q     <= done_d;
      state_q    <= state_d;
      out_port_q <= out_port_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_CTRL:    readdata[CTRL_W-1:0]   = ctrl_q;
      ADDR_PATTERN: readdata[LED_W-1:0]    = pattern_q;
      ADDR_PERIOD:  readdata[PERIOD_W-1:0] = period_q;
      default: begin
        readdata[STATUS_DONE_BIT] = done_q;
        readdata[STATUS_RUN_BIT]  = (state_q == ST_RUN);
      end
    endcase
  end

  assign out_port = out_port_q;
  assign irq      = irq_q;

endmodule
